// File: rtl/latch_wr_seq_pkg.sv
// ============================================================================
//  latch_wr_seq_pkg
//  Shared types and constants for the latch write sequencer.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package latch_wr_seq_pkg;

    // Sequencer phases: address/data setup, enable pulse, data hold
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Fixed phase lengths around the enable pulse
    localparam int SETUP_CYC = 1;
    localparam int HOLD_CYC  = 1;

    // Width of the enable-pulse duration counter
    localparam int CNT_W = 3;

endpackage : latch_wr_seq_pkg

`default_nettype wire

// File: rtl/latch_wr_seq_cnt.sv
// ============================================================================
//  latch_wr_seq_cnt
//  Loadable down-counter with zero flag; saturates at zero (never wraps).
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module latch_wr_seq_cnt
    import latch_wr_seq_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: load has priority, decrement only while non-zero
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register, cleared asynchronously
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule : latch_wr_seq_cnt

`default_nettype wire

// File: rtl/latch_wr_seq.sv
// ============================================================================
//  latch_wr_seq
//  Sequences writes into an array of transparent latches: presents data,
//  waits one setup cycle, pulses the one-hot enable for PULSE_CYC cycles,
//  holds data one more cycle, then signals completion.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module latch_wr_seq
    import latch_wr_seq_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int WORDS     = 6,
    parameter int AW        = 3,
    parameter int PULSE_CYC = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [AW-1:0]    REQ_ADDR,
    input  logic [WIDTH-1:0] REQ_DATA,
    output logic [WIDTH-1:0] LAT_D,
    output logic [WORDS-1:0] LAT_E,
    output logic             DONE,
    output logic             ERR
);

    // One extra bit so WORDS == 2**AW still fits for the range compare
    localparam logic [AW:0]      WORDS_C  = (AW+1)'(WORDS);
    localparam logic [WORDS-1:0] ONEHOT_C = WORDS'(1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);

    state_t           state_q;
    logic [AW-1:0]    addr_q;
    logic [WIDTH-1:0] lat_d_q;
    logic [WORDS-1:0] lat_e_q;
    logic             ready_q;
    logic             done_q;
    logic             err_q;

    logic             hs;
    logic             addr_ok;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;

    assign hs       = REQ_VALID && ready_q;
    assign addr_ok  = ({1'b0, REQ_ADDR} < WORDS_C);

    // Counter is armed while in SETUP so it is loaded on entry to OPEN
    assign cnt_load = (state_q == SETUP);
    assign cnt_dec  = (state_q == OPEN) && !cnt_zero;

    latch_wr_seq_cnt u_cnt (
        .CLK        (CLK),
        .RST        (RST),
        .load_i     (cnt_load),
        .load_val_i (PULSE_LD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Sequencer FSM; every output is a flop so latch pins see no glitches
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            addr_q  <= '0;
            lat_d_q <= '0;
            lat_e_q <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (hs) begin
                        if (addr_ok) begin
                            addr_q  <= REQ_ADDR;
                            lat_d_q <= REQ_DATA;
                            ready_q <= 1'b0;
                            state_q <= SETUP;
                        end else begin
                            // Out-of-range target: report and stay ready
                            err_q <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    lat_e_q <= ONEHOT_C << addr_q;
                    state_q <= OPEN;
                end
                OPEN: begin
                    if (cnt_zero) begin
                        lat_e_q <= '0;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    done_q  <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    lat_e_q <= '0;
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign REQ_READY = ready_q;
    assign LAT_D     = lat_d_q;
    assign LAT_E     = lat_e_q;
    assign DONE      = done_q;
    assign ERR       = err_q;

endmodule : latch_wr_seq

`default_nettype wire

// File: tb/tb_latch_wr_seq.sv
// ============================================================================
//  tb_latch_wr_seq
//  Directed self-checking bench for latch_wr_seq (default, PULSE_CYC=1 and
//  PULSE_CYC=8 instances sharing one set of inputs).
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_latch_wr_seq;

    localparam int W = 8;
    localparam int N = 6;
    localparam int A = 3;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         valid = 1'b0;
    logic [A-1:0] addr  = '0;
    logic [W-1:0] data  = '0;

    logic         ready,  done,  err;
    logic [W-1:0] lat_d;
    logic [N-1:0] lat_e;
    logic         ready1, done1, err1;
    logic [W-1:0] lat_d1;
    logic [N-1:0] lat_e1;
    logic         ready8, done8, err8;
    logic [W-1:0] lat_d8;
    logic [N-1:0] lat_e8;

    int n_checks = 0;
    int n_fail   = 0;

    latch_wr_seq #(.WIDTH(W), .WORDS(N), .AW(A), .PULSE_CYC(2)) dut (
        .CLK(clk), .RST(rst), .REQ_VALID(valid), .REQ_READY(ready),
        .REQ_ADDR(addr), .REQ_DATA(data), .LAT_D(lat_d), .LAT_E(lat_e),
        .DONE(done), .ERR(err)
    );

    latch_wr_seq #(.WIDTH(W), .WORDS(N), .AW(A), .PULSE_CYC(1)) dut_p1 (
        .CLK(clk), .RST(rst), .REQ_VALID(valid), .REQ_READY(ready1),
        .REQ_ADDR(addr), .REQ_DATA(data), .LAT_D(lat_d1), .LAT_E(lat_e1),
        .DONE(done1), .ERR(err1)
    );

    latch_wr_seq #(.WIDTH(W), .WORDS(N), .AW(A), .PULSE_CYC(8)) dut_p8 (
        .CLK(clk), .RST(rst), .REQ_VALID(valid), .REQ_READY(ready8),
        .REQ_ADDR(addr), .REQ_DATA(data), .LAT_D(lat_d8), .LAT_E(lat_e8),
        .DONE(done8), .ERR(err8)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst   = 1'b1;
        valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        tick();
        tick();
        n_checks++; if (lat_e !== '0)   begin n_fail++; $display("FAIL reset_lat_e: got %b expected 0", lat_e); end
        n_checks++; if (lat_d !== '0)   begin n_fail++; $display("FAIL reset_lat_d: got %h expected 0", lat_d); end
        n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (err !== 1'b0)   begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready); end
        rst = 1'b0;
        #2;
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_pre_edge: got %b expected 0", ready); end
        tick();
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_first_edge: got %b expected 1", ready); end
    endtask

    task automatic test_basic;
        logic [N-1:0] exp_e;
        valid = 1'b1; addr = 3'd2; data = 8'hA5;
        tick();
        valid = 1'b0; data = 8'h00;
        for (int k = 1; k <= 6; k++) begin
            exp_e = (k == 2 || k == 3) ? 6'b000100 : 6'b000000;
            n_checks++; if (lat_d !== 8'hA5) begin n_fail++; $display("FAIL basic_lat_d c%0d: got %h expected a5", k, lat_d); end
            n_checks++; if (lat_e !== exp_e) begin n_fail++; $display("FAIL basic_lat_e c%0d: got %b expected %b", k, lat_e, exp_e); end
            n_checks++; if (done !== (k == 5)) begin n_fail++; $display("FAIL basic_done c%0d: got %b expected %b", k, done, (k == 5)); end
            n_checks++; if (ready !== (k >= 5)) begin n_fail++; $display("FAIL basic_ready c%0d: got %b expected %b", k, ready, (k >= 5)); end
            if (k < 6) tick();
        end
    endtask

    task automatic test_back_to_back;
        logic [N-1:0] exp_e;
        logic [W-1:0] exp_d;
        valid = 1'b1; addr = 3'd0; data = 8'h11;
        tick();
        for (int k = 1; k <= 10; k++) begin
            exp_e = (k == 2 || k == 3) ? 6'b000001 :
                    (k == 7 || k == 8) ? 6'b100000 : 6'b000000;
            exp_d = (k <= 5) ? 8'h11 : 8'h22;
            n_checks++; if (lat_e !== exp_e) begin n_fail++; $display("FAIL b2b_lat_e c%0d: got %b expected %b", k, lat_e, exp_e); end
            n_checks++; if (lat_d !== exp_d) begin n_fail++; $display("FAIL b2b_lat_d c%0d: got %h expected %h", k, lat_d, exp_d); end
            n_checks++; if (done !== (k == 5 || k == 10)) begin n_fail++; $display("FAIL b2b_done c%0d: got %b expected %b", k, done, (k == 5 || k == 10)); end
            n_checks++; if ($countones(lat_e) > 1) begin n_fail++; $display("FAIL b2b_onehot c%0d: got %b expected at most one bit", k, lat_e); end
            if (k < 5) begin
                valid = 1'b1; addr = 3'd0; data = 8'h99;
            end else if (k == 5) begin
                valid = 1'b1; addr = 3'd5; data = 8'h22;
            end else begin
                valid = 1'b0;
            end
            if (k < 10) tick();
        end
    endtask

    task automatic test_ignore;
        logic [N-1:0] exp_e;
        valid = 1'b1; addr = 3'd4; data = 8'h4B;
        tick();
        for (int k = 1; k <= 6; k++) begin
            exp_e = (k == 2 || k == 3) ? 6'b010000 : 6'b000000;
            n_checks++; if (lat_d !== 8'h4B) begin n_fail++; $display("FAIL ignore_lat_d c%0d: got %h expected 4b", k, lat_d); end
            n_checks++; if (lat_e !== exp_e) begin n_fail++; $display("FAIL ignore_lat_e c%0d: got %b expected %b", k, lat_e, exp_e); end
            n_checks++; if (done !== (k == 5)) begin n_fail++; $display("FAIL ignore_done c%0d: got %b expected %b", k, done, (k == 5)); end
            if (k <= 3) begin
                valid = (k != 2);
                addr  = 3'($urandom_range(0, 5));
                data  = 8'($urandom);
            end else begin
                valid = 1'b0;
            end
            if (k < 6) tick();
        end
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL ignore_idle_ready: got %b expected 1", ready); end
    endtask

    task automatic test_err;
        int n_done;
        int n_err;
        valid = 1'b1; addr = 3'd6; data = 8'h77;
        tick();
        n_checks++; if (err !== 1'b1)   begin n_fail++; $display("FAIL err_pulse: got %b expected 1", err); end
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL err_ready: got %b expected 1", ready); end
        n_checks++; if (lat_e !== '0)   begin n_fail++; $display("FAIL err_lat_e: got %b expected 0", lat_e); end
        n_checks++; if (lat_d !== 8'h4B) begin n_fail++; $display("FAIL err_lat_d: got %h expected 4b", lat_d); end
        n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL err_done: got %b expected 0", done); end
        addr = 3'd4; data = 8'h3C;
        tick();
        valid = 1'b0;
        n_checks++; if (err !== 1'b0)   begin n_fail++; $display("FAIL err_single: got %b expected 0", err); end
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL err_next_accept_ready: got %b expected 0", ready); end
        n_checks++; if (lat_d !== 8'h3C) begin n_fail++; $display("FAIL err_next_accept_d: got %h expected 3c", lat_d); end
        n_done = 0;
        n_err  = 0;
        for (int k = 2; k <= 7; k++) begin
            tick();
            if (done) n_done++;
            if (err)  n_err++;
            if (k == 5) begin
                n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL err_next_done: got %b expected 1", done); end
            end
        end
        n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL err_done_count: got %0d expected 1", n_done); end
        n_checks++; if (n_err != 0)  begin n_fail++; $display("FAIL err_extra_err: got %0d expected 0", n_err); end
    endtask

    task automatic test_abort;
        valid = 1'b1; addr = 3'd1; data = 8'h5A;
        tick();
        valid = 1'b0;
        tick();
        n_checks++; if (lat_e !== 6'b000010) begin n_fail++; $display("FAIL abort_open: got %b expected 000010", lat_e); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (lat_e !== '0)   begin n_fail++; $display("FAIL abort_async_lat_e: got %b expected 0", lat_e); end
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready: got %b expected 0", ready); end
        n_checks++; if (lat_d !== '0)   begin n_fail++; $display("FAIL abort_lat_d: got %h expected 0", lat_d); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done_in_rst c%0d: got %b expected 0", k, done); end
        end
        rst = 1'b0;
        #2;
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready_pre_edge: got %b expected 0", ready); end
        tick();
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready_after: got %b expected 1", ready); end
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (done !== 1'b0 || lat_e !== '0) begin n_fail++; $display("FAIL abort_no_done c%0d: got done=%b lat_e=%b expected 0/0", k, done, lat_e); end
            tick();
        end
    endtask

    task automatic test_pulse;
        int cnt1, cnt8, d1, d8;
        do_reset();
        cnt1 = 0; cnt8 = 0; d1 = -1; d8 = -1;
        valid = 1'b1; addr = 3'd3; data = 8'hC3;
        tick();
        valid = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            if (lat_e1[3]) cnt1++;
            if (lat_e8[3]) cnt8++;
            if (done1 && d1 < 0) d1 = k;
            if (done8 && d8 < 0) d8 = k;
            if ((lat_e1 & ~6'b001000) != '0 || (lat_e8 & ~6'b001000) != '0) begin
                n_checks++; n_fail++;
                $display("FAIL pulse_stray_bit c%0d: got p1=%b p8=%b expected only bit 3", k, lat_e1, lat_e8);
            end
            tick();
        end
        n_checks++; if (cnt1 != 1)  begin n_fail++; $display("FAIL pulse1_width: got %0d expected 1", cnt1); end
        n_checks++; if (d1 != 4)    begin n_fail++; $display("FAIL pulse1_latency: got %0d expected 4", d1); end
        n_checks++; if (cnt8 != 8)  begin n_fail++; $display("FAIL pulse8_width: got %0d expected 8", cnt8); end
        n_checks++; if (d8 != 11)   begin n_fail++; $display("FAIL pulse8_latency: got %0d expected 11", d8); end
        n_checks++; if (lat_d8 !== 8'hC3) begin n_fail++; $display("FAIL pulse8_lat_d: got %h expected c3", lat_d8); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore();
        test_err();
        test_abort();
        test_pulse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule : tb_latch_wr_seq

`default_nettype wire
